// File: rtl/instr_encoder.sv
// RV32I instruction word encoder with a one-deep output register and LI pseudo-op expansion.
// Optional macro ENC_RANGE_CHECK_EN flags immediates that do not fit their format.
module instr_encoder #(
    parameter int unsigned LI_OPT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [2:0]  FMT,
    input  logic [6:0]  OPCODE,
    input  logic [4:0]  RD,
    input  logic [4:0]  RS1,
    input  logic [4:0]  RS2,
    input  logic [2:0]  FUNCT3,
    input  logic [6:0]  FUNCT7,
    input  logic [31:0] IMM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INSTR,
    output logic        OUT_ERR
);

    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_ADDI = 7'b0010011;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FULL, LI_HI} state_t;

    state_t      state;
    logic [31:0] instr_q;
    logic [31:0] addi_q;
    logic        err_q;

    logic [19:0] li_hi;
    logic [31:0] enc_word;
    logic [31:0] enc_addi;
    logic        enc_err;
    logic        enc_two;

    // Rounded upper part so that LUI + sign-extended ADDI reconstructs IMM.
    assign li_hi = IMM[31:12] + 20'(IMM[11]);

    // Encode the current request; LI yields a first word and an optional pending ADDI.
    always_comb begin
        enc_word = NOP;
        enc_addi = {IMM[11:0], RD, 3'b000, RD, OP_ADDI};
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (FMT)
            3'd0: enc_word = {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE};
            3'd1: enc_word = {IMM[11:0], RS1, FUNCT3, RD, OPCODE};
            3'd2: enc_word = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE};
            3'd3: enc_word = {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE};
            3'd4: enc_word = {IMM[31:12], RD, OPCODE};
            3'd5: enc_word = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE};
            3'd6: begin
                if ((LI_OPT != 0) && (li_hi == 20'd0)) begin
                    enc_word = {IMM[11:0], 5'd0, 3'b000, RD, OP_ADDI};
                end else begin
                    enc_word = {li_hi, RD, OP_LUI};
                    enc_two  = 1'b1;
                end
            end
            default: begin
                enc_word = NOP;
                enc_err  = 1'b1;
            end
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (FMT)
            3'd1, 3'd2: enc_err = (IMM != {{20{IMM[11]}}, IMM[11:0]});
            3'd3:       enc_err = (IMM != {{19{IMM[12]}}, IMM[12:0]}) || IMM[0];
            3'd4:       enc_err = (IMM[11:0] != 12'd0);
            3'd5:       enc_err = (IMM != {{11{IMM[20]}}, IMM[20:0]}) || IMM[0];
            default:    ;
        endcase
`endif
    end

    assign IN_READY  = (state == IDLE) | ((state == FULL) & OUT_READY);
    assign OUT_VALID = (state != IDLE);
    assign OUT_INSTR = instr_q;
    assign OUT_ERR   = err_q;

    // Output register and handshake FSM; reset wins over any handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            instr_q <= 32'd0;
            addi_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        instr_q <= enc_word;
                        err_q   <= enc_err;
                        addi_q  <= enc_addi;
                        state   <= enc_two ? LI_HI : FULL;
                    end
                end
                FULL: begin
                    if (OUT_READY) begin
                        if (IN_VALID) begin
                            instr_q <= enc_word;
                            err_q   <= enc_err;
                            addi_q  <= enc_addi;
                            state   <= enc_two ? LI_HI : FULL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LI_HI: begin
                    if (OUT_READY) begin
                        instr_q <= addi_q;
                        err_q   <= 1'b0;
                        state   <= FULL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports SHALL be named CLK and RST.
REQ-002 Parameter SHALL be: LI_OPT, 1, when 1 a LI whose upper part is zero emits only the ADDI word.
REQ-003 Ports SHALL be, one per line, name direction width meaning:
- CLK in 1 rising-edge clock
- RST in 1 synchronous active-high reset
- IN_VALID in 1 request valid
- IN_READY out 1 request accepted when IN_VALID & IN_READY at the edge
- FMT in 3 0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
- OPCODE in 7 opcode field, ignored for LI
- RD, RS1, RS2 in 5 each register fields
- FUNCT3 in 3, FUNCT7 in 7 function fields
- IMM in 32 byte immediate, two's complement
- OUT_VALID out 1 instruction word valid
- OUT_READY in 1 consumer accepts word when OUT_VALID & OUT_READY at the edge
- OUT_INSTR out 32 encoded RV32I instruction word
- OUT_ERR out 1 sideband error for the current word

Function
REQ-004 Encoding SHALL be: R={FUNCT7,RS2,RS1,FUNCT3,RD,OPCODE}; I={IMM[11:0],RS1,FUNCT3,RD,OPCODE}; S={IMM[11:5],RS2,RS1,FUNCT3,IMM[4:0],OPCODE}; B={IMM[12],IMM[10:5],RS2,RS1,FUNCT3,IMM[4:1],IMM[11],OPCODE}; U={IMM[31:12],RD,OPCODE}; J={IMM[20],IMM[10:1],IMM[11],IMM[19:12],RD,OPCODE}.
REQ-005 LI SHALL emit LUI {HI,RD,0110111} and then ADDI {IMM[11:0],RD,000,RD,0010011}, where HI=(IMM+32'h800)[31:12].
REQ-006 With LI_OPT=1 and HI==0, LI SHALL emit only ADDI {IMM[11:0],5'd0,000,RD,0010011}.
REQ-007 FSM states SHALL be IDLE (output empty), FULL (holding last or only word), LI_HI (holding LUI, ADDI pending).
REQ-008 Transitions: IDLE+accept -> FULL, or LI_HI for a two-word LI; LI_HI+OUT_READY -> FULL with ADDI loaded; FULL+OUT_READY -> IDLE, or directly to FULL/LI_HI when a new request is accepted in the same cycle.
REQ-009 IN_READY SHALL be combinational = (state==IDLE) | (state==FULL & OUT_READY); it SHALL be 0 in LI_HI.
REQ-010 OUT_VALID SHALL be 1 exactly in FULL and LI_HI; OUT_INSTR and OUT_ERR SHALL be registered and SHALL stay stable while OUT_VALID & !OUT_READY.
REQ-011 Latency SHALL be one cycle: a request accepted at edge N is presented from edge N onward, visible in cycle N+1; sustained throughput SHALL be one word per cycle.
REQ-012 FMT=7 SHALL emit 32'h00000013 (NOP) with OUT_ERR=1 regardless of configuration.
REQ-013 For a two-word LI, OUT_ERR SHALL be 0 on both words.

Reset
REQ-014 RST SHALL force state IDLE, OUT_VALID=0, OUT_INSTR=0, OUT_ERR=0 at the next edge, overriding any handshake in the same cycle.
REQ-015 RST during LI_HI SHALL discard the pending ADDI; it SHALL never be emitted.

Configuration
REQ-016 With macro ENC_RANGE_CHECK_EN defined, OUT_ERR SHALL be 1 when: I/S and IMM != sext(IMM[11:0]); B and (IMM != sext(IMM[12:0]) or IMM[0]); J and (IMM != sext(IMM[20:0]) or IMM[0]); U and IMM[11:0]!=0; the word SHALL still be emitted truncated as REQ-004.
REQ-017 Without ENC_RANGE_CHECK_EN, these checks SHALL be absent and OUT_ERR SHALL be 1 only for REQ-012.

Verification
REQ-018 FMT=1, OPCODE=0010011, RD=5, RS1=6, FUNCT3=0, IMM=32'hFFFFFFFF, OUT_READY=1 -> OUT_INSTR=32'hFFF30293 next cycle, OUT_ERR=0.
REQ-019 FMT=6, RD=10, IMM=32'h12345FFF -> 32'h12346537 then 32'hFFF50513; IN_READY=0 while the LUI is held.
REQ-020 LI_OPT=1, FMT=6, RD=1, IMM=32'h00000123 -> single word 32'h12300093, then IDLE.
REQ-021 FMT=3, IMM=32'h00000003 -> OUT_ERR=1 with ENC_RANGE_CHECK_EN, 0 without; FMT=7 -> 32'h00000013, OUT_ERR=1 in both builds.
REQ-022 OUT_READY=0 for 3 cycles after accept -> OUT_INSTR/OUT_ERR constant, IN_READY=0; back-to-back requests with OUT_READY=1 -> one word per cycle, none lost.
REQ-023 RST=1 in LI_HI -> OUT_VALID=0 next cycle, ADDI never appears, next request encodes normally.
